muntjac_ras: RTL and testbench

//  Return address stack for the fetch-stage branch predictor. Sits directly downstream of

---
 rtl/muntjac_pkg.sv | 14 +
 rtl/muntjac_ras.sv | 101 ++++++++++
 tb/tb_muntjac_ras.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muntjac_pkg.sv
// Shared predictor types used across the fetch stage.
package muntjac_pkg;

    typedef enum logic [2:0] {
        BRANCH_NONE,
        BRANCH_UNTAKEN,
        BRANCH_TAKEN,
        BRANCH_JUMP,
        BRANCH_CALL,
        BRANCH_RET,
        BRANCH_YIELD
    } branch_type_e;

endpackage

// File: rtl/muntjac_ras.sv
// Return address stack: pushes link on predicted calls, supplies return targets, restores checkpoints.
// Latency: updates land at the next clk_i edge; outputs are a pure function of current state.
// Backpressure: none; every cycle accepts one op, and a restore drops the concurrent pred op.
module muntjac_ras
    import muntjac_pkg::*;
#(
    parameter int unsigned AddrLen = 64,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrWidth = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pred_valid_i,
    input  branch_type_e        pred_branch_type_i,
    input  logic [AddrLen-1:0]  pred_link_i,
    output logic                ret_valid_o,
    output logic [AddrLen-1:0]  ret_addr_o,
    output logic [PtrWidth-1:0] ckpt_ptr_o,
    output logic [PtrWidth:0]   ckpt_cnt_o,
    output logic [AddrLen-1:0]  ckpt_top_o,
    input  logic                restore_valid_i,
    input  logic [PtrWidth-1:0] restore_ptr_i,
    input  logic [PtrWidth:0]   restore_cnt_i,
    input  logic [AddrLen-1:0]  restore_top_i
);

    localparam logic [PtrWidth:0]   DepthCnt = (PtrWidth + 1)'(Depth);
    localparam logic [PtrWidth-1:0] PtrOne   = PtrWidth'(1);
    localparam logic [PtrWidth:0]   CntOne   = (PtrWidth + 1)'(1);

    logic [AddrLen-2:0]  entry_q [Depth];
    logic [PtrWidth-1:0] ptr_q, ptr_d;
    logic [PtrWidth:0]   cnt_q, cnt_d;
    logic [PtrWidth:0]   restore_cnt;
    logic                push, pop;
    logic                wr_en;
    logic [PtrWidth-1:0] wr_idx;
    logic [AddrLen-2:0]  wr_dat;

    // A concurrent restore marks this cycle's prediction as wrong-path.
    assign push = pred_valid_i && !restore_valid_i && (pred_branch_type_i == BRANCH_CALL);
    assign pop  = pred_valid_i && !restore_valid_i && (pred_branch_type_i == BRANCH_RET)
                  && (cnt_q != '0);

    assign restore_cnt = (restore_cnt_i > DepthCnt) ? DepthCnt : restore_cnt_i;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        wr_dat = '0;
        if (restore_valid_i) begin
            ptr_d  = restore_ptr_i;
            cnt_d  = restore_cnt;
            wr_en  = 1'b1;
            wr_idx = restore_ptr_i;
            wr_dat = restore_top_i[AddrLen-1:1];
        end else if (push) begin
            // On overflow the write wraps onto the oldest entry; occupancy saturates.
            ptr_d  = ptr_q + PtrOne;
            cnt_d  = (cnt_q == DepthCnt) ? cnt_q : cnt_q + CntOne;
            wr_en  = 1'b1;
            wr_idx = ptr_q + PtrOne;
            wr_dat = pred_link_i[AddrLen-1:1];
        end else if (pop) begin
            ptr_d = ptr_q - PtrOne;
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                entry_q[wr_idx] <= wr_dat;
            end
        end
    end

    assign ret_valid_o = (cnt_q != '0);
    assign ret_addr_o  = {entry_q[ptr_q], 1'b0};
    assign ckpt_ptr_o  = ptr_q;
    assign ckpt_cnt_o  = cnt_q;
    assign ckpt_top_o  = {entry_q[ptr_q], 1'b0};

    a_push_pop_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0({push, pop}));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= DepthCnt);
    a_restore_cnt_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        restore_valid_i |-> (restore_cnt_i <= DepthCnt));

endmodule

// File: tb/tb_muntjac_ras.sv
// Directed and scoreboarded random checks of the return address stack (Depth 8, 64-bit addresses).
module tb_muntjac_ras;
    import muntjac_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         pred_valid_i;
    branch_type_e pred_branch_type_i;
    logic [63:0]  pred_link_i;
    logic         ret_valid_o;
    logic [63:0]  ret_addr_o;
    logic [2:0]   ckpt_ptr_o;
    logic [3:0]   ckpt_cnt_o;
    logic [63:0]  ckpt_top_o;
    logic         restore_valid_i;
    logic [2:0]   restore_ptr_i;
    logic [3:0]   restore_cnt_i;
    logic [63:0]  restore_top_i;

    int n_checks = 0;
    int n_pass = 0;

    muntjac_ras #(.AddrLen(64), .Depth(8)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .pred_valid_i       (pred_valid_i),
        .pred_branch_type_i (pred_branch_type_i),
        .pred_link_i        (pred_link_i),
        .ret_valid_o        (ret_valid_o),
        .ret_addr_o         (ret_addr_o),
        .ckpt_ptr_o         (ckpt_ptr_o),
        .ckpt_cnt_o         (ckpt_cnt_o),
        .ckpt_top_o         (ckpt_top_o),
        .restore_valid_i    (restore_valid_i),
        .restore_ptr_i      (restore_ptr_i),
        .restore_cnt_i      (restore_cnt_i),
        .restore_top_i      (restore_top_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        pred_valid_i       = 1'b0;
        pred_branch_type_i = BRANCH_NONE;
        pred_link_i        = '0;
        restore_valid_i    = 1'b0;
        restore_ptr_i      = '0;
        restore_cnt_i      = '0;
        restore_top_i      = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic do_push(input logic [63:0] link);
        pred_valid_i = 1'b1;
        pred_branch_type_i = BRANCH_CALL;
        pred_link_i = link;
        step();
        clear_inputs();
    endtask

    task automatic do_pop();
        pred_valid_i = 1'b1;
        pred_branch_type_i = BRANCH_RET;
        step();
        clear_inputs();
    endtask

    task automatic do_restore(input logic [2:0] p, input logic [3:0] c, input logic [63:0] t);
        restore_valid_i = 1'b1;
        restore_ptr_i = p;
        restore_cnt_i = c;
        restore_top_i = t;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (ret_valid_o !== 1'b0) $display("FAIL reset_valid act=%b exp=0", ret_valid_o); else n_pass++;
        n_checks++; if (ret_addr_o !== 64'h0) $display("FAIL reset_addr act=%h exp=0", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_cnt_o !== 4'd0) $display("FAIL reset_cnt act=%0d exp=0", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd0) $display("FAIL reset_ptr act=%0d exp=0", ckpt_ptr_o); else n_pass++;
        n_checks++; if (ckpt_top_o !== 64'h0) $display("FAIL reset_top act=%h exp=0", ckpt_top_o); else n_pass++;
        do_pop();
        n_checks++; if (ckpt_cnt_o !== 4'd0) $display("FAIL underflow_cnt act=%0d exp=0", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd0) $display("FAIL underflow_ptr act=%0d exp=0", ckpt_ptr_o); else n_pass++;
        n_checks++; if (ret_valid_o !== 1'b0) $display("FAIL underflow_valid act=%b exp=0", ret_valid_o); else n_pass++;
    endtask

    task automatic test_push_pop();
        do_push(64'h1004);
        n_checks++; if (ret_addr_o !== 64'h1004) $display("FAIL push1_addr act=%h exp=1004", ret_addr_o); else n_pass++;
        do_push(64'h2008);
        n_checks++; if (ret_addr_o !== 64'h2008) $display("FAIL push2_addr act=%h exp=2008", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_cnt_o !== 4'd2) $display("FAIL push2_cnt act=%0d exp=2", ckpt_cnt_o); else n_pass++;
        do_pop();
        n_checks++; if (ret_addr_o !== 64'h1004) $display("FAIL pop_addr act=%h exp=1004", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_cnt_o !== 4'd1) $display("FAIL pop_cnt act=%0d exp=1", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ret_valid_o !== 1'b1) $display("FAIL pop_valid act=%b exp=1", ret_valid_o); else n_pass++;
    endtask

    task automatic test_checkpoint();
        logic [2:0]  ck_ptr;
        logic [3:0]  ck_cnt;
        logic [63:0] ck_top;
        ck_ptr = ckpt_ptr_o;
        ck_cnt = ckpt_cnt_o;
        ck_top = ckpt_top_o;
        n_checks++; if (ck_ptr !== 3'd1) $display("FAIL ckpt_ptr act=%0d exp=1", ck_ptr); else n_pass++;
        n_checks++; if (ck_cnt !== 4'd1) $display("FAIL ckpt_cnt act=%0d exp=1", ck_cnt); else n_pass++;
        n_checks++; if (ck_top !== 64'h1004) $display("FAIL ckpt_top act=%h exp=1004", ck_top); else n_pass++;
        do_push(64'h3000);
        n_checks++; if (ret_addr_o !== 64'h3000) $display("FAIL wrong_push act=%h exp=3000", ret_addr_o); else n_pass++;
        do_pop();
        do_pop();
        n_checks++; if (ret_valid_o !== 1'b0) $display("FAIL wrong_pops_valid act=%b exp=0", ret_valid_o); else n_pass++;
        do_push(64'h5000);
        n_checks++; if (ret_addr_o !== 64'h5000) $display("FAIL clobber_push act=%h exp=5000", ret_addr_o); else n_pass++;
        do_restore(ck_ptr, ck_cnt, ck_top);
        n_checks++; if (ret_addr_o !== 64'h1004) $display("FAIL restore_addr act=%h exp=1004", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_cnt_o !== 4'd1) $display("FAIL restore_cnt act=%0d exp=1", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd1) $display("FAIL restore_ptr act=%0d exp=1", ckpt_ptr_o); else n_pass++;
    endtask

    task automatic test_restore_priority();
        // Concurrent call must be dropped; entry 2 still holds 0x3000 from the previous test.
        pred_valid_i = 1'b1;
        pred_branch_type_i = BRANCH_CALL;
        pred_link_i = 64'h4000;
        do_restore(3'd1, 4'd1, 64'h1004);
        n_checks++; if (ret_addr_o !== 64'h1004) $display("FAIL prio_call_addr act=%h exp=1004", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_cnt_o !== 4'd1) $display("FAIL prio_call_cnt act=%0d exp=1", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd1) $display("FAIL prio_call_ptr act=%0d exp=1", ckpt_ptr_o); else n_pass++;
        pred_valid_i = 1'b1;
        pred_branch_type_i = BRANCH_RET;
        do_restore(3'd3, 4'd2, 64'h7770);
        n_checks++; if (ret_addr_o !== 64'h7770) $display("FAIL prio_ret_addr act=%h exp=7770", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_cnt_o !== 4'd2) $display("FAIL prio_ret_cnt act=%0d exp=2", ckpt_cnt_o); else n_pass++;
        do_pop();
        n_checks++; if (ret_addr_o !== 64'h3000) $display("FAIL prio_below_addr act=%h exp=3000", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd2) $display("FAIL prio_below_ptr act=%0d exp=2", ckpt_ptr_o); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [63:0] exp_addr;
        apply_reset();
        for (int i = 1; i <= 9; i++) begin
            do_push(64'h100 * i);
        end
        n_checks++; if (ckpt_cnt_o !== 4'd8) $display("FAIL ovf_cnt act=%0d exp=8", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ret_addr_o !== 64'h900) $display("FAIL ovf_top act=%h exp=900", ret_addr_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd1) $display("FAIL ovf_ptr act=%0d exp=1", ckpt_ptr_o); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_addr = 64'h900 - 64'h100 * i;
            n_checks++; if (ret_addr_o !== exp_addr) $display("FAIL ovf_pop%0d act=%h exp=%h", i, ret_addr_o, exp_addr); else n_pass++;
            do_pop();
        end
        n_checks++; if (ret_valid_o !== 1'b0) $display("FAIL ovf_drained act=%b exp=0", ret_valid_o); else n_pass++;
        do_pop();
        n_checks++; if (ckpt_cnt_o !== 4'd0) $display("FAIL ovf_underflow act=%0d exp=0", ckpt_cnt_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) begin
            do_push(64'hA000 + 64'h10 * i);
        end
        n_checks++; if (ckpt_cnt_o !== 4'd5) $display("FAIL mid_cnt_pre act=%0d exp=5", ckpt_cnt_o); else n_pass++;
        rst_i = 1'b1;
        restore_valid_i = 1'b1;
        restore_ptr_i = 3'd2;
        restore_cnt_i = 4'd3;
        restore_top_i = 64'hABC0;
        step();
        rst_i = 1'b0;
        clear_inputs();
        n_checks++; if (ckpt_cnt_o !== 4'd0) $display("FAIL mid_rst_cnt act=%0d exp=0", ckpt_cnt_o); else n_pass++;
        n_checks++; if (ckpt_ptr_o !== 3'd0) $display("FAIL mid_rst_ptr act=%0d exp=0", ckpt_ptr_o); else n_pass++;
        n_checks++; if (ret_valid_o !== 1'b0) $display("FAIL mid_rst_valid act=%b exp=0", ret_valid_o); else n_pass++;
        n_checks++; if (ret_addr_o !== 64'h0) $display("FAIL mid_rst_addr act=%h exp=0", ret_addr_o); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [63:0] saved[$];
        int          plan[$];
        int          normal_left;
        bit          in_wrong;
        int          kind;
        int          r;
        int          room;
        logic [2:0]  ck_ptr;
        logic [3:0]  ck_cnt;
        logic [63:0] ck_top;
        logic [63:0] link;
        apply_reset();
        q = {};
        ck_ptr = '0;
        ck_cnt = '0;
        ck_top = '0;
        normal_left = $urandom_range(1, 6);
        in_wrong = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_inputs();
            link = {$urandom, $urandom};
            if (!in_wrong && normal_left == 0) begin
                ck_ptr = ckpt_ptr_o;
                ck_cnt = ckpt_cnt_o;
                ck_top = ckpt_top_o;
                saved = q;
                in_wrong = 1'b1;
                // Wrong paths that never clobber anything below the checkpointed top.
                case ($urandom_range(0, 2))
                    0: begin
                        room = 8 - q.size();
                        for (int i = 0; i < ((room > 2) ? 2 : room); i++) plan.push_back(0);
                    end
                    1: begin
                        plan.push_back(1);
                        plan.push_back(0);
                    end
                    default: repeat ($urandom_range(1, 3)) plan.push_back(1);
                endcase
            end
            if (in_wrong) begin
                kind = (plan.size() == 0) ? 4 : plan.pop_front();
            end else begin
                r = $urandom_range(0, 9);
                kind = (r < 4) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : 3;
                normal_left--;
            end
            case (kind)
                0: begin
                    pred_valid_i = 1'b1;
                    pred_branch_type_i = BRANCH_CALL;
                    pred_link_i = link;
                    q.push_back(link & ~64'h1);
                    if (q.size() > 8) void'(q.pop_front());
                end
                1: begin
                    pred_valid_i = 1'b1;
                    pred_branch_type_i = BRANCH_RET;
                    if (q.size() != 0) void'(q.pop_back());
                end
                2: begin
                    pred_valid_i = 1'b1;
                    pred_branch_type_i = BRANCH_JUMP;
                    pred_link_i = link;
                end
                3: begin
                    pred_branch_type_i = BRANCH_CALL;
                    pred_link_i = link;
                end
                default: begin
                    restore_valid_i = 1'b1;
                    restore_ptr_i = ck_ptr;
                    restore_cnt_i = ck_cnt;
                    restore_top_i = ck_top;
                    pred_valid_i = 1'($urandom_range(0, 1));
                    pred_branch_type_i = ($urandom_range(0, 1) != 0) ? BRANCH_CALL : BRANCH_RET;
                    pred_link_i = link;
                    q = saved;
                    in_wrong = 1'b0;
                    normal_left = $urandom_range(1, 6);
                end
            endcase
            step();
            n_checks++; if (ckpt_cnt_o !== 4'(q.size())) $display("FAIL rnd_cnt cyc=%0d act=%0d exp=%0d", cyc, ckpt_cnt_o, q.size()); else n_pass++;
            n_checks++; if (ret_valid_o !== (q.size() != 0)) $display("FAIL rnd_valid cyc=%0d act=%b exp=%b", cyc, ret_valid_o, q.size() != 0); else n_pass++;
            if (q.size() != 0) begin
                n_checks++; if (ret_addr_o !== q[$]) $display("FAIL rnd_addr cyc=%0d act=%h exp=%h", cyc, ret_addr_o, q[$]); else n_pass++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_push_pop();
        test_checkpoint();
        test_restore_priority();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
